// File: rtl/dac_spi_tx.sv
// Serial transmitter for 12-bit DDS samples into a DAC121S101-style 16-bit SPI frame.
// Optional one-entry skid buffer enabled by defining DAC_SPI_TX_SKIDBUF_EN.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DATA_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [1:0]        power_mode,
  output logic              dac_sync,
  output logic              dac_sclk,
  output logic              dac_din,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned CNT_W   = $clog2(2 * CLK_DIV + 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt;
  logic               sync_nxt, sclk_nxt, din_nxt, busy_nxt, done_nxt, ready_nxt;
  logic               active_c;
  logic               hs_c;
  logic [FRAME_W-1:0] frame_c;

`ifdef DAC_SPI_TX_SKIDBUF_EN
  logic               buf_full, buf_full_nxt;
  logic [FRAME_W-1:0] buf_data, buf_data_nxt;
`endif

  assign hs_c    = sample_valid && sample_ready;
  assign frame_c = FRAME_W'({2'b00, power_mode, sample});

  // Next-state, datapath and next-output decode; pins are registered from these.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    done_nxt    = 1'b0;
`ifdef DAC_SPI_TX_SKIDBUF_EN
    buf_full_nxt = buf_full;
    buf_data_nxt = buf_data;
`endif
    if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);

    case (state)
      IDLE: begin
        if (hs_c) begin
          state_nxt = SETUP;
          shreg_nxt = frame_c;
          cnt_nxt   = HALF_LD;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt   = SHIFT_LO;
          bit_cnt_nxt = '0;
          cnt_nxt     = HALF_LD;
        end
      end
      SHIFT_LO: begin
        if (cnt == '0) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LD;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = SHIFT_HI;
            shreg_nxt = {shreg[FRAME_W-2:0], 1'b0};
            cnt_nxt   = HALF_LD;
          end
        end
      end
      SHIFT_HI: begin
        if (cnt == '0) begin
          state_nxt   = SHIFT_LO;
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          cnt_nxt     = HALF_LD;
        end
      end
      GAP: begin
        if (cnt == '0) begin
`ifdef DAC_SPI_TX_SKIDBUF_EN
          if (buf_full) begin
            state_nxt    = SETUP;
            shreg_nxt    = buf_data;
            buf_full_nxt = 1'b0;
            cnt_nxt      = HALF_LD;
          end else if (hs_c) begin
            state_nxt = SETUP;
            shreg_nxt = frame_c;
            cnt_nxt   = HALF_LD;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

`ifdef DAC_SPI_TX_SKIDBUF_EN
    // Samples arriving mid-frame park in the buffer; IDLE and the last GAP cycle load directly.
    if (hs_c && !(state == IDLE || (state == GAP && cnt == '0))) begin
      buf_full_nxt = 1'b1;
      buf_data_nxt = frame_c;
    end
    ready_nxt = !buf_full_nxt;
`else
    ready_nxt = (state_nxt == IDLE);
`endif

    active_c = (state_nxt == SETUP) || (state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI);
    sync_nxt = !active_c;
    sclk_nxt = (state_nxt != SHIFT_LO);
    din_nxt  = active_c && shreg_nxt[FRAME_W-1];
    busy_nxt = (state_nxt != IDLE);
  end

  // State, datapath and registered pin outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      dac_sync     <= 1'b1;
      dac_sclk     <= 1'b1;
      dac_din      <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      sample_ready <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shreg        <= shreg_nxt;
      dac_sync     <= sync_nxt;
      dac_sclk     <= sclk_nxt;
      dac_din      <= din_nxt;
      busy         <= busy_nxt;
      frame_done   <= done_nxt;
      sample_ready <= ready_nxt;
    end
  end

`ifdef DAC_SPI_TX_SKIDBUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      buf_full <= buf_full_nxt;
      buf_data <= buf_data_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: one instance at CLK_DIV=2, one at CLK_DIV=1.
// Times are edge indices: a value seen at a falling clk edge is what the next rising edge samples.
module tb_dac_spi_tx;

  logic        clk;
  logic        rst;
  logic [11:0] sample2, sample1;
  logic        valid2, valid1;
  logic [1:0]  pm2, pm1;
  logic        ready2, sync2, sclk2, din2, busy2, done2;
  logic        ready1, sync1, sclk1, din1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  dac_spi_tx #(.CLK_DIV(2), .DATA_W(12)) u_dut2 (
    .clk(clk), .rst(rst), .sample(sample2), .sample_valid(valid2), .sample_ready(ready2),
    .power_mode(pm2), .dac_sync(sync2), .dac_sclk(sclk2), .dac_din(din2),
    .busy(busy2), .frame_done(done2)
  );

  dac_spi_tx #(.CLK_DIV(1), .DATA_W(12)) u_dut1 (
    .clk(clk), .rst(rst), .sample(sample1), .sample_valid(valid1), .sample_ready(ready1),
    .power_mode(pm1), .dac_sync(sync1), .dac_sclk(sclk1), .dac_din(din1),
    .busy(busy1), .frame_done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor for the CLK_DIV=2 instance.
  logic        p_sync2 = 1'b1, p_sclk2 = 1'b1, p_ready2 = 1'b1, p_busy2 = 1'b0;
  logic [15:0] sh2 = '0;
  int          bits2 = 0, f2 = 0, falls2 = 0;
  int          done_obs2 = 0, rdy_rise2 = 0, rdy_fall2 = 0, busy_fall2 = 0;
  logic [15:0] frm2   [0:15];
  int          fb2    [0:15];
  int          ffall2 [0:15];
  int          frise2 [0:15];

  always @(negedge clk) begin
    p_sync2  <= sync2;
    p_sclk2  <= sclk2;
    p_ready2 <= ready2;
    p_busy2  <= busy2;
    if (p_sync2 && !sync2) begin
      sh2   <= '0;
      bits2 <= 0;
      if (f2 < 16) ffall2[f2[3:0]] <= cyc + 1;
    end else if (!p_sync2 && sync2) begin
      if (f2 < 16) begin
        frm2[f2[3:0]]   <= sh2;
        fb2[f2[3:0]]    <= bits2;
        frise2[f2[3:0]] <= cyc + 1;
      end
      f2 <= f2 + 1;
    end
    if (p_sclk2 && !sclk2) begin
      falls2 <= falls2 + 1;
      if (!sync2) begin
        sh2   <= {sh2[14:0], din2};
        bits2 <= bits2 + 1;
      end
    end
    if (done2) done_obs2 <= cyc + 1;
    if (!p_ready2 && ready2) rdy_rise2 <= cyc + 1;
    if (p_ready2 && !ready2) rdy_fall2 <= cyc + 1;
    if (p_busy2 && !busy2) busy_fall2 <= cyc + 1;
  end

  // Frame monitor for the CLK_DIV=1 instance.
  logic        p_sync1 = 1'b1, p_sclk1 = 1'b1;
  logic [15:0] sh1 = '0;
  int          bits1 = 0, f1 = 0;
  logic [15:0] frm1   [0:15];
  int          fb1    [0:15];
  int          ffall1 [0:15];

  always @(negedge clk) begin
    p_sync1 <= sync1;
    p_sclk1 <= sclk1;
    if (p_sync1 && !sync1) begin
      sh1   <= '0;
      bits1 <= 0;
      if (f1 < 16) ffall1[f1[3:0]] <= cyc + 1;
    end else if (!p_sync1 && sync1) begin
      if (f1 < 16) begin
        frm1[f1[3:0]] <= sh1;
        fb1[f1[3:0]]  <= bits1;
      end
      f1 <= f1 + 1;
    end
    if (p_sclk1 && !sclk1 && !sync1) begin
      sh1   <= {sh1[14:0], din1};
      bits1 <= bits1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a sample to the CLK_DIV=2 instance; t is the rising edge that accepts it.
  task automatic send2(input logic [11:0] s, input logic [1:0] p, output int t);
    int g;
    g       = 0;
    sample2 = s;
    pm2     = p;
    valid2  = 1'b1;
    while (!ready2 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("send2_accept", 32'(ready2), 32'd1);
    t = cyc + 1;
    @(negedge clk);
    valid2 = 1'b0;
  endtask

  task automatic wait_f2(input int n);
    int g;
    g = 0;
    while (f2 < n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("wait_frame2", 32'(f2 >= n), 32'd1);
  endtask

  int         t, ta, tb, k, base, g;
  logic [3:0] idx;

  initial begin
    rst = 1'b0;
    sample2 = '0; valid2 = 1'b0; pm2 = 2'b00;
    sample1 = '0; valid1 = 1'b0; pm1 = 2'b00;
    #12;
    check("rst_sync",  32'(sync2),  32'd1);
    check("rst_sclk",  32'(sclk2),  32'd1);
    check("rst_din",   32'(din2),   32'd0);
    check("rst_ready", 32'(ready2), 32'd1);
    check("rst_busy",  32'(busy2),  32'd0);
    check("rst_done",  32'(done2),  32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Idle after reset release: nothing moves.
    repeat (100) @(negedge clk);
    check("idle_sclk_falls", 32'(falls2), 32'd0);
    check("idle_frames",     32'(f2),     32'd0);
    check("idle_sync",       32'(sync2),  32'd1);
    check("idle_sclk",       32'(sclk2),  32'd1);
    check("idle_din",        32'(din2),   32'd0);
    check("idle_ready",      32'(ready2), 32'd1);
    check("idle_busy",       32'(busy2),  32'd0);
    check("idle_done_seen",  32'(done_obs2), 32'd0);

    // Single frame 0xABC, normal power mode.
    send2(12'hABC, 2'b00, t);
    wait_f2(1);
    repeat (8) @(negedge clk);
    check("abc_frame",     32'(frm2[0]), 32'h0ABC);
    check("abc_bits",      32'(fb2[0]), 32'd16);
    check("abc_sync_fall", 32'(ffall2[0]), 32'(t + 1));
    check("abc_sync_low",  32'(frise2[0] - ffall2[0]), 32'd64);
    check("abc_done",      32'(done_obs2), 32'(t + 65));
    check("abc_busy_fall", 32'(busy_fall2), 32'(t + 69));
`ifndef DAC_SPI_TX_SKIDBUF_EN
    check("abc_ready_fall", 32'(rdy_fall2), 32'(t + 1));
    check("abc_ready_rise", 32'(rdy_rise2), 32'(t + 69));
`endif

    // Power-down bits plus full-scale then zero, sent back to back.
    send2(12'hFFF, 2'b11, ta);
    send2(12'h000, 2'b00, tb);
    wait_f2(3);
    check("pd_frame_fff", 32'(frm2[1]), 32'h3FFF);
    check("pd_frame_000", 32'(frm2[2]), 32'h0000);
    check("pd_bits",      32'(fb2[2]), 32'd16);
`ifdef DAC_SPI_TX_SKIDBUF_EN
    check("pd_gap", 32'(ffall2[2] - frise2[1]), 32'd4);
`else
    check("pd_gap", 32'(ffall2[2] - frise2[1]), 32'd5);
`endif

    // CLK_DIV=1 ramp with valid held high.
    k = 0;
    g = 0;
    while (k < 6 && g < 2000) begin
      sample1 = 12'(k);
      valid1  = 1'b1;
      if (ready1) k++;
      @(negedge clk);
      g++;
    end
    valid1 = 1'b0;
    g = 0;
    while (f1 < 6 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("ramp_frames", 32'(f1), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ramp_val%0d", i), 32'(frm1[i]), 32'(i));
      check($sformatf("ramp_bits%0d", i), 32'(fb1[i]), 32'd16);
    end
    for (int i = 0; i < 5; i++) begin
`ifdef DAC_SPI_TX_SKIDBUF_EN
      check($sformatf("ramp_period%0d", i), 32'(ffall1[i+1] - ffall1[i]), 32'd34);
`else
      check($sformatf("ramp_period%0d", i), 32'(ffall1[i+1] - ffall1[i]), 32'd35);
`endif
    end

    // Reset after the seventh falling SCLK edge of frame 0x15A5.
    send2(12'h5A5, 2'b01, t);
    g = 0;
    while (!(bits2 == 7 && !sync2) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("mid_bits7_reached", 32'(bits2), 32'd7);
    check("mid_first7", 32'(sh2[6:0]), 32'h0A);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_sync",  32'(sync2),  32'd1);
    check("mid_rst_sclk",  32'(sclk2),  32'd1);
    check("mid_rst_din",   32'(din2),   32'd0);
    check("mid_rst_busy",  32'(busy2),  32'd0);
    check("mid_rst_ready", 32'(ready2), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    base = f2;
    idx  = base[3:0];
    send2(12'h2C3, 2'b10, t);
    wait_f2(base + 1);
    check("post_rst_frame",    32'(frm2[idx]), 32'h22C3);
    check("post_rst_bits",     32'(fb2[idx]), 32'd16);
    check("post_rst_sync_low", 32'(frise2[idx] - ffall2[idx]), 32'd64);
    check("post_rst_fall",     32'(ffall2[idx]), 32'(t + 1));

    // Valid pulse while a frame is in flight.
    repeat (6) @(negedge clk);
    base = f2;
    idx  = base[3:0];
    send2(12'h123, 2'b00, t);
    repeat (10) @(negedge clk);
    sample2 = 12'h555;
    valid2  = 1'b1;
`ifdef DAC_SPI_TX_SKIDBUF_EN
    check("busy_pulse_ready", 32'(ready2), 32'd1);
`else
    check("busy_pulse_ready", 32'(ready2), 32'd0);
`endif
    @(negedge clk);
    valid2 = 1'b0;
    check("busy_ready_after", 32'(ready2), 32'd0);
    wait_f2(base + 1);
    repeat (100) @(negedge clk);
    check("busy_frame", 32'(frm2[idx]), 32'h0123);
`ifdef DAC_SPI_TX_SKIDBUF_EN
    check("busy_frame_count", 32'(f2), 32'(base + 2));
    check("busy_buffered", 32'(frm2[idx + 4'd1]), 32'h0555);
`else
    check("busy_frame_count", 32'(f2), 32'(base + 1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

- Serial transmitter that feeds 12-bit DDS amplitude samples to an external 12-bit SPI-style DAC (DAC121S101 frame format).
- Sits downstream of the phase-to-amplitude stage. Accepts one sample per valid/ready handshake.
- Sends each sample as a 16-bit frame on SYNC/SCLK/DIN, MSB first, with a programmable SCLK divider and a guaranteed SYNC-high gap between frames.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles; legal range ≥1.
- `DATA_W`, default 12: sample width; frame is always 16 bits, so `DATA_W` must be 12.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `sample` in 12: unsigned offset-binary amplitude.
- `sample_valid` in 1: `sample` is presented.
- `sample_ready` out 1: block can accept a sample this cycle.
- `power_mode` in 2: DAC PD1:PD0 bits; sampled at handshake; 00 = normal.
- `dac_sync` out 1: frame sync, active-low.
- `dac_sclk` out 1: serial clock; idles high.
- `dac_din` out 1: serial data; DAC samples it on the falling edge of `dac_sclk`.
- `busy` out 1: high whenever state ≠ IDLE.
- `frame_done` out 1: one-cycle pulse when the last bit has been clocked out.

## Operation
- Handshake: a transfer occurs on a rising edge where `sample_valid && sample_ready`.
- At handshake, latch the 16-bit shift register as {2'b00, `power_mode`, `sample`}.
- States and transitions:
  - IDLE -> SETUP on handshake.
  - SETUP -> SHIFT_LO after `CLK_DIV` cycles.
  - SHIFT_LO -> SHIFT_HI after `CLK_DIV` cycles if bits remain; otherwise -> GAP.
  - SHIFT_HI -> SHIFT_LO after `CLK_DIV` cycles.
  - GAP -> IDLE after 2·`CLK_DIV` cycles.
- IDLE: `dac_sync`=1, `dac_sclk`=1, `dac_din`=0, `sample_ready`=1.
- SETUP: `dac_sync`=0, `dac_sclk`=1, `dac_din`=bit15.
- SHIFT_LO: `dac_sclk`=0. Entering SHIFT_LO is a falling edge, where the DAC captures the current bit.
- SHIFT_HI: `dac_sclk`=1. On entry, shift left; `dac_din` takes the next bit.
- Bit counter 0..15 counts falling edges. After the 16th falling edge (bit0), `dac_sclk` stays low for `CLK_DIV` cycles, then goes to GAP.
- GAP: `dac_sync`=1, `dac_sclk`=1, `dac_din`=0. `frame_done` pulses in the first GAP cycle.
- All outputs are registered; no combinational path from inputs to DAC pins.
- `sample_ready` depends only on state (and buffer flag when configured), never on `sample_valid`.
- Divider counter width: $clog2(2·`CLK_DIV`+1). It reloads on every state transition.
- Reset mid-frame: all outputs go immediately to IDLE values and the frame is abandoned. After release, the block starts in IDLE.

## Timing
- Reset values:
  - `dac_sync`=1, `dac_sclk`=1, `dac_din`=0.
  - `sample_ready`=1, `busy`=0, `frame_done`=0.
- Handshake at edge t:
  - `dac_sync` falls at t+1.
  - `dac_sync` stays low for 32·`CLK_DIV` cycles.
  - GAP lasts 2·`CLK_DIV` cycles.
  - `sample_ready` returns at t+1+34·`CLK_DIV`.
- `CLK_DIV`=2: `dac_sync` low cycles t+1..t+64; `frame_done` at t+65; ready at t+69. The per-sample period is therefore 69 cycles.
- Data setup before each falling SCLK edge is `CLK_DIV` cycles; hold after it is `CLK_DIV` cycles.
- `sample_valid` while not ready: ignored; the sample is held by the source.

## Configuration
- `DAC_SPI_TX_SKIDBUF_EN` defined:
  - Adds a one-entry holding register. `sample_ready` = !buffer_full, so a sample can be accepted during SETUP, SHIFT or GAP.
  - At GAP end with the buffer full, go directly to SETUP, loading from the buffer and skipping IDLE.
  - Back-to-back period is 1+34·`CLK_DIV`−1 = 68 cycles at `CLK_DIV`=2.
  - Reset clears the buffer.
- Undefined: no buffer; `sample_ready` is high only in IDLE.

## Test plan
- Reset release, no valid -> outputs hold at reset values for 100 cycles; no SCLK edges.
- `CLK_DIV`=2, sample 0xABC, `power_mode`=00 -> DIN at 16 falling edges reads 0x0ABC MSB first; SYNC low 64 cycles; `frame_done` at t+65; ready at t+69.
- `power_mode`=11, sample 0xFFF, then 0x000 -> frames 0x3FFF then 0x0000; SYNC-high gap ≥4 cycles between them.
- `CLK_DIV`=1, `sample_valid` held high with ramp 0,1,2,… -> each frame carries the next value with none skipped or duplicated; period 35 cycles, or 34 with `DAC_SPI_TX_SKIDBUF_EN`.
- `rst` asserted at falling edge 7 of a frame -> SYNC=1, SCLK=1, DIN=0 immediately; the next handshake after release produces a complete, correct 16-bit frame.
- `sample_valid` pulsed while busy (macro off) -> not accepted; ready stays low; frame in flight is unchanged.
